// File: rtl/apb_rr_arbiter_if.sv
// APB port bundle used on both the requester side and the downstream side
// of apb_rr_arbiter.
interface apb_rr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        output paddr,
        output pwdata,
        output pwrite,
        output psel,
        output penable,
        input  pready,
        input  prdata
    );

    modport slave (
        input  paddr,
        input  pwdata,
        input  pwrite,
        input  psel,
        input  penable,
        output pready,
        output prdata
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-requester APB arbiter: captures the winning transfer, replays it
// downstream with registered outputs and returns the response to the winner.
module apb_rr_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk_a,
    input  logic             rst,
    apb_rr_arbiter_if.slave  m0,
    apb_rr_arbiter_if.slave  m1,
    apb_rr_arbiter_if.master s,
    output logic [1:0]       grant,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        grant_q, grant_d;
    logic [1:0]        hold_q, hold_d;
    logic [1:0]        rdy_q, rdy_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              spsel_q, spsel_d;
    logic              spen_q, spen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;

    logic [1:0] psel;
    logic [1:0] pen;
    logic [1:0] req;
    logic       win;

    assign psel = {m1.psel, m0.psel};
    assign pen  = {m1.penable, m0.penable};
    // A held requester only blocks while it still shows penable from the
    // transfer it just finished; a fresh setup phase rearms it at once.
    assign req  = psel & ~(hold_q & pen);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q & pen;
        rdy_d   = 2'b00;
        last_d  = last_q;
        busy_d  = busy_q;
        spsel_d = spsel_q;
        spen_d  = spen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        win     = 1'b0;

        unique case (state_q)
            IDLE: begin
                unique case (req)
                    2'b01:   win = 1'b0;
                    2'b10:   win = 1'b1;
                    2'b11:   win = FIXED_PRIO ? 1'b0 : ~last_q;
                    default: win = 1'b0;
                endcase
                if (|req) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    addr_d  = win ? m1.paddr : m0.paddr;
                    wdata_d = win ? m1.pwdata : m0.pwdata;
                    write_d = win ? m1.pwrite : m0.pwrite;
                    spsel_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                spen_d  = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (s.pready) begin
                    spsel_d = 1'b0;
                    spen_d  = 1'b0;
                    rdy_d   = grant_q;
                    if (grant_q[1]) rd1_d = s.prdata;
                    else            rd0_d = s.prdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                hold_d  = (hold_q & pen) | grant_q;
                last_d  = grant_q[1];
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            hold_q  <= 2'b00;
            rdy_q   <= 2'b00;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
            spsel_q <= 1'b0;
            spen_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            rdy_q   <= rdy_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            spsel_q <= spsel_d;
            spen_q  <= spen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign s.paddr   = addr_q;
    assign s.pwdata  = wdata_q;
    assign s.pwrite  = write_q;
    assign s.psel    = spsel_q;
    assign s.penable = spen_q;

    assign m0.pready = rdy_q[0];
    assign m0.prdata = rd0_q;
    assign m1.pready = rdy_q[1];
    assign m1.prdata = rd1_q;

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: round-robin and fixed-priority
// instances share requester stimulus; one is observed at a time.
module tb_apb_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_psel[2];
    logic        m_pen[2];
    logic        m_wr[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wd[2];
    logic        s_rdy;
    logic [31:0] s_rd;
    logic        sel_fp;

    apb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) r0();
    apb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) r1();
    apb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) rs();
    apb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) f0();
    apb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) f1();
    apb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) fs();

    assign r0.psel    = m_psel[0];
    assign r0.penable = m_pen[0];
    assign r0.pwrite  = m_wr[0];
    assign r0.paddr   = m_addr[0];
    assign r0.pwdata  = m_wd[0];
    assign r1.psel    = m_psel[1];
    assign r1.penable = m_pen[1];
    assign r1.pwrite  = m_wr[1];
    assign r1.paddr   = m_addr[1];
    assign r1.pwdata  = m_wd[1];
    assign f0.psel    = m_psel[0];
    assign f0.penable = m_pen[0];
    assign f0.pwrite  = m_wr[0];
    assign f0.paddr   = m_addr[0];
    assign f0.pwdata  = m_wd[0];
    assign f1.psel    = m_psel[1];
    assign f1.penable = m_pen[1];
    assign f1.pwrite  = m_wr[1];
    assign f1.paddr   = m_addr[1];
    assign f1.pwdata  = m_wd[1];
    assign rs.pready  = s_rdy;
    assign rs.prdata  = s_rd;
    assign fs.pready  = s_rdy;
    assign fs.prdata  = s_rd;

    logic [1:0] gr, gr_f;
    logic       bz, bz_f;

    apb_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) dut (
        .clk_a (clk),
        .rst   (rst),
        .m0    (r0),
        .m1    (r1),
        .s     (rs),
        .grant (gr),
        .busy  (bz)
    );

    apb_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk_a (clk),
        .rst   (rst),
        .m0    (f0),
        .m1    (f1),
        .s     (fs),
        .grant (gr_f),
        .busy  (bz_f)
    );

    logic rdy[2];
    assign rdy[0] = sel_fp ? f0.pready : r0.pready;
    assign rdy[1] = sel_fp ? f1.pready : r1.pready;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Log every downstream setup phase of the observed instance.
    logic [1:0]  q_g[$];
    logic [31:0] q_a[$];
    bit          mon = 1'b0;

    always @(negedge clk) begin
        if (mon) begin
            if (sel_fp) begin
                if (fs.psel && !fs.penable) begin
                    q_g.push_back(gr_f);
                    q_a.push_back(fs.paddr);
                end
            end else if (rs.psel && !rs.penable) begin
                q_g.push_back(gr);
                q_a.push_back(rs.paddr);
            end
        end
    end

    task automatic xfer(input int i, input logic [31:0] a, input logic w);
        int n;
        m_psel[i] = 1'b1;
        m_pen[i]  = 1'b0;
        m_addr[i] = a;
        m_wd[i]   = ~a;
        m_wr[i]   = w;
        tick;
        m_pen[i] = 1'b1;
        n = 0;
        while (!rdy[i] && n < 50) begin
            tick;
            n++;
        end
        chk("xfer_done", {63'd0, rdy[i]}, 64'd1);
        tick;
    endtask

    task automatic idle_all;
        for (int i = 0; i < 2; i++) begin
            m_psel[i] = 1'b0;
            m_pen[i]  = 1'b0;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_all();
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    logic [1:0]  exp_g[4];
    logic [31:0] exp_a[4];

    task automatic chk_order(input string tag);
        chk({tag, "_n"}, 64'(q_g.size()), 64'd4);
        for (int k = 0; k < q_g.size() && k < 4; k++) begin
            chk({tag, "_grant"}, 64'(q_g[k]), 64'(exp_g[k]));
            chk({tag, "_addr"}, 64'(q_a[k]), 64'(exp_a[k]));
        end
    endtask

    initial begin
        rst    = 1'b1;
        sel_fp = 1'b0;
        s_rdy  = 1'b1;
        s_rd   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            m_psel[i] = 1'b0;
            m_pen[i]  = 1'b0;
            m_wr[i]   = 1'b0;
            m_addr[i] = 32'h0;
            m_wd[i]   = 32'h0;
        end
        tick;
        tick;
        chk("rst_spsel", {63'd0, rs.psel}, 64'd0);
        chk("rst_spen", {63'd0, rs.penable}, 64'd0);
        chk("rst_grant", {62'd0, gr}, 64'd0);
        chk("rst_busy", {63'd0, bz}, 64'd0);
        chk("rst_rdy", {62'd0, r1.pready, r0.pready}, 64'd0);
        chk("rst_paddr", {32'd0, rs.paddr}, 64'd0);
        chk("rst_prdata", {32'd0, r0.prdata}, 64'd0);
        rst = 1'b0;
        tick;

        // Single write, zero wait states.
        s_rd      = 32'h1111_2222;
        m_psel[0] = 1'b1;
        m_pen[0]  = 1'b0;
        m_addr[0] = 32'h0000_0010;
        m_wd[0]   = 32'hA5A5_0001;
        m_wr[0]   = 1'b1;
        chk("t1_idle", {63'd0, rs.psel}, 64'd0);
        tick;
        chk("t1_setup", {62'd0, rs.psel, rs.penable}, 64'd2);
        chk("t1_grant", {62'd0, gr}, 64'd1);
        chk("t1_paddr", {32'd0, rs.paddr}, 64'h10);
        chk("t1_pwdata", {32'd0, rs.pwdata}, 64'hA5A5_0001);
        chk("t1_pwrite", {63'd0, rs.pwrite}, 64'd1);
        m_pen[0] = 1'b1;
        tick;
        chk("t1_access", {62'd0, rs.psel, rs.penable}, 64'd3);
        chk("t1_rdy_early", {63'd0, r0.pready}, 64'd0);
        tick;
        chk("t1_m0_rdy", {63'd0, r0.pready}, 64'd1);
        chk("t1_m1_rdy", {63'd0, r1.pready}, 64'd0);
        chk("t1_prdata", {32'd0, r0.prdata}, 64'h1111_2222);
        chk("t1_s_drop", {62'd0, rs.psel, rs.penable}, 64'd0);
        tick;
        idle_all();
        chk("t1_end", {60'd0, r0.pready, gr, bz}, 64'd0);

        // Read with five wait states.
        s_rdy     = 1'b0;
        m_psel[1] = 1'b1;
        m_pen[1]  = 1'b0;
        m_addr[1] = 32'h20;
        m_wr[1]   = 1'b0;
        tick;
        m_pen[1] = 1'b1;
        chk("t2_grant", {62'd0, gr}, 64'd2);
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("t2_busy", {63'd0, bz}, 64'd1);
            chk("t2_spen", {63'd0, rs.penable}, 64'd1);
            chk("t2_rdy", {63'd0, r1.pready}, 64'd0);
            tick;
        end
        s_rdy = 1'b1;
        s_rd  = 32'hCAFE_F00D;
        chk("t2_spen_last", {63'd0, rs.penable}, 64'd1);
        tick;
        chk("t2_m1_rdy", {63'd0, r1.pready}, 64'd1);
        chk("t2_prdata", {32'd0, r1.prdata}, 64'hCAFE_F00D);
        chk("t2_busy_resp", {63'd0, bz}, 64'd1);
        chk("t2_m0_rdy", {63'd0, r0.pready}, 64'd0);
        chk("t2_m0_keep", {32'd0, r0.prdata}, 64'h1111_2222);
        tick;
        idle_all();
        chk("t2_rdy_off", {63'd0, r1.pready}, 64'd0);
        chk("t2_hold_data", {32'd0, r1.prdata}, 64'hCAFE_F00D);
        chk("t2_idle", {63'd0, bz}, 64'd0);

        // Requester keeps psel/penable high after completion.
        m_psel[0] = 1'b1;
        m_pen[0]  = 1'b0;
        m_addr[0] = 32'h30;
        m_wr[0]   = 1'b0;
        tick;
        m_pen[0] = 1'b1;
        tick;
        tick;
        chk("t5_rdy", {63'd0, r0.pready}, 64'd1);
        for (int k = 0; k < 2; k++) begin
            tick;
            chk("t5_no_repeat", {62'd0, rs.psel, bz}, 64'd0);
        end
        m_pen[0]  = 1'b0;
        m_addr[0] = 32'h34;
        chk("t5_setup_idle", {63'd0, rs.psel}, 64'd0);
        tick;
        chk("t5_regrant", {63'd0, rs.psel}, 64'd1);
        chk("t5_paddr", {32'd0, rs.paddr}, 64'h34);
        m_pen[0] = 1'b1;
        tick;
        tick;
        chk("t5_rdy2", {63'd0, r0.pready}, 64'd1);
        tick;
        idle_all();

        // Reset while downstream is in its access phase.
        s_rdy     = 1'b0;
        m_psel[1] = 1'b1;
        m_pen[1]  = 1'b0;
        m_addr[1] = 32'h40;
        m_wr[1]   = 1'b1;
        tick;
        m_pen[1] = 1'b1;
        tick;
        chk("t6_access", {63'd0, rs.penable}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_s_off", {62'd0, rs.psel, rs.penable}, 64'd0);
        chk("t6_grant", {62'd0, gr}, 64'd0);
        chk("t6_busy", {63'd0, bz}, 64'd0);
        chk("t6_rdy", {62'd0, r1.pready, r0.pready}, 64'd0);
        idle_all();
        s_rdy = 1'b1;
        tick;
        rst = 1'b0;
        tick;

        // Round-robin ordering with both requesters busy.
        q_g.delete();
        q_a.delete();
        mon = 1'b1;
        fork
            begin
                xfer(0, 32'h100, 1'b1);
                xfer(0, 32'h104, 1'b1);
                m_psel[0] = 1'b0;
                m_pen[0]  = 1'b0;
            end
            begin
                xfer(1, 32'h200, 1'b0);
                xfer(1, 32'h204, 1'b0);
                m_psel[1] = 1'b0;
                m_pen[1]  = 1'b0;
            end
        join
        tick;
        mon = 1'b0;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_a = '{32'h100, 32'h200, 32'h104, 32'h204};
        chk_order("rr");

        // Fixed priority: requester 1 waits until requester 0 goes idle.
        sel_fp = 1'b1;
        do_reset();
        q_g.delete();
        q_a.delete();
        mon = 1'b1;
        fork
            begin
                xfer(0, 32'h100, 1'b0);
                xfer(0, 32'h104, 1'b0);
                xfer(0, 32'h108, 1'b0);
                m_psel[0] = 1'b0;
                m_pen[0]  = 1'b0;
            end
            begin
                xfer(1, 32'h200, 1'b1);
                m_psel[1] = 1'b0;
                m_pen[1]  = 1'b0;
            end
        join
        tick;
        mon = 1'b0;
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b10};
        exp_a = '{32'h100, 32'h104, 32'h108, 32'h200};
        chk_order("fp");
        chk("fp_idle", {63'd0, bz_f}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
